// File: rtl/if_id_stage_reg_if.sv
// Instruction-memory read channel between the fetch unit and the IF/ID
// stage register. The fetch unit drives the response; the stage returns ready.
interface if_id_stage_reg_if #(
  parameter int XLEN = 32
);
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic [XLEN-1:0] imem_pc;
  logic            imem_rready;

  modport master (
    output imem_rvalid,
    output imem_rdata,
    output imem_pc,
    input  imem_rready
  );

  modport slave (
    input  imem_rvalid,
    input  imem_rdata,
    input  imem_pc,
    output imem_rready
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register for the 5-stage RV32I core.
// Holds one instruction between fetch and decode, stalls on load-use
// hazards, parks one in-flight fetch in a skid entry while stalled, and
// squashes everything on an EX redirect. Also counts stalled valid cycles.
module if_id_stage_reg #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  if_id_stage_reg_if.slave imem,
  input  logic             load_use_hazard,
  input  logic             flush,
  output logic             if_id_valid,
  output logic [31:0]      if_id_instr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [6:0]       if_id_opcode,
  output logic [4:0]       if_id_rd_idx,
  output logic [4:0]       if_id_rs1_idx,
  output logic [4:0]       if_id_rs2_idx,
  output logic             fetch_hold,
  output logic [CNT_W-1:0] stall_cycles
);

  // RUN: skid empty. SKID: skid holds one fetched instruction + pc.
  typedef enum logic {
    RUN  = 1'b0,
    SKID = 1'b1
  } state_e;

  state_e           state_q;
  logic             valid_q;
  logic [31:0]      instr_q;
  logic [XLEN-1:0]  pc_q;
  logic [31:0]      skid_instr_q;
  logic [XLEN-1:0]  skid_pc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic skid_full;
  logic advance;
  logic accept;

  assign skid_full        = (state_q == SKID);
  assign advance          = !load_use_hazard;
  assign imem.imem_rready = !skid_full;
  assign accept           = imem.imem_rvalid && !skid_full;

  assign fetch_hold    = skid_full;
  assign if_id_valid   = valid_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc      = pc_q;
  assign if_id_opcode  = instr_q[6:0];
  assign if_id_rd_idx  = instr_q[11:7];
  assign if_id_rs1_idx = instr_q[19:15];
  assign if_id_rs2_idx = instr_q[24:20];

  // Stage/skid control: flush beats stall beats normal flow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else if (flush) begin
      // Wrong-path work is dropped, including a fetch accepted this cycle.
      state_q <= RUN;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (advance) begin
            if (accept) begin
              valid_q <= 1'b1;
              instr_q <= imem.imem_rdata;
              pc_q    <= imem.imem_pc;
            end else begin
              valid_q <= 1'b0;
              instr_q <= NOP_INSTR;
              pc_q    <= '0;
            end
          end else if (accept) begin
            // Stage is frozen; park the response so it is not lost.
            skid_instr_q <= imem.imem_rdata;
            skid_pc_q    <= imem.imem_pc;
            state_q      <= SKID;
          end
        end
        SKID: begin
          if (advance) begin
            valid_q <= 1'b1;
            instr_q <= skid_instr_q;
            pc_q    <= skid_pc_q;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating count of cycles where a real instruction is held by a stall.
  always_comb begin
    cnt_d = cnt_q;
    if (load_use_hazard && valid_q && !flush && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: directed vector table, hand sequences for
// counter saturation and reset-with-skid-full, then random traffic against
// a queue-based reference model.
module tb_if_id_stage_reg;
  localparam int          XLEN  = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_use_hazard;
  logic             flush;
  logic             if_id_valid;
  logic [31:0]      if_id_instr;
  logic [XLEN-1:0]  if_id_pc;
  logic [6:0]       if_id_opcode;
  logic [4:0]       if_id_rd_idx, if_id_rs1_idx, if_id_rs2_idx;
  logic             fetch_hold;
  logic [CNT_W-1:0] stall_cycles;

  if_id_stage_reg_if #(.XLEN(XLEN)) imem_bus ();

  if_id_stage_reg #(.XLEN(XLEN), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem            (imem_bus.slave),
    .load_use_hazard (load_use_hazard),
    .flush           (flush),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_opcode    (if_id_opcode),
    .if_id_rd_idx    (if_id_rd_idx),
    .if_id_rs1_idx   (if_id_rs1_idx),
    .if_id_rs2_idx   (if_id_rs2_idx),
    .fetch_hold      (fetch_hold),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        rst_n, rv;
    logic [31:0] rd, pc;
    logic        haz, fl;
    logic        ev;
    logic [31:0] ei, ep;
    logic        erdy;
    int          ecnt;
  } vec_t;

  vec_t tbl[16];

  // Reference model: stage contents, skid as a queue, plain-integer counter.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } fetch_t;
  logic        m_v;
  logic [31:0] m_i, m_pc;
  fetch_t      m_skid[$];
  int          m_cnt;

  task automatic model_reset();
    m_v = 1'b0; m_i = NOP; m_pc = '0; m_skid.delete(); m_cnt = 0;
  endtask

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rd,
                            input logic [31:0] pc, input logic haz, input logic fl);
    bit     acc;
    bit     was_valid;
    fetch_t f;
    if (!r) begin
      model_reset();
      return;
    end
    acc       = rv && (m_skid.size() == 0);
    was_valid = m_v;
    if (fl) begin
      m_v = 1'b0; m_i = NOP; m_pc = '0; m_skid.delete();
    end else if (haz) begin
      if (acc) begin f.instr = rd; f.pc = pc; m_skid.push_back(f); end
    end else if (m_skid.size() != 0) begin
      f = m_skid.pop_front();
      m_v = 1'b1; m_i = f.instr; m_pc = f.pc;
    end else if (acc) begin
      m_v = 1'b1; m_i = rd; m_pc = pc;
    end else begin
      m_v = 1'b0; m_i = NOP; m_pc = '0;
    end
    if (haz && was_valid && !fl && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic cmp(input string tag, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got %h want %h", tag, f, act, exp);
    end
  endtask

  task automatic check(input string tag, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep, input logic erdy, input int ecnt);
    logic [31:0] e;
    e = ei;
    vectors++;
    cmp(tag, "valid",  {31'b0, if_id_valid},        {31'b0, ev});
    cmp(tag, "instr",  if_id_instr,                  ei);
    cmp(tag, "pc",     if_id_pc,                     ep);
    cmp(tag, "opcode", {25'b0, if_id_opcode},        {25'b0, e[6:0]});
    cmp(tag, "rd",     {27'b0, if_id_rd_idx},        {27'b0, e[11:7]});
    cmp(tag, "rs1",    {27'b0, if_id_rs1_idx},       {27'b0, e[19:15]});
    cmp(tag, "rs2",    {27'b0, if_id_rs2_idx},       {27'b0, e[24:20]});
    cmp(tag, "rready", {31'b0, imem_bus.imem_rready}, {31'b0, erdy});
    cmp(tag, "hold",   {31'b0, fetch_hold},          {31'b0, !erdy});
    cmp(tag, "stalls", {28'b0, stall_cycles},        ecnt);
  endtask

  task automatic apply(input logic r, input logic rv, input logic [31:0] rd,
                       input logic [31:0] pc, input logic haz, input logic fl);
    @(negedge clk);
    rst_n = r; imem_bus.imem_rvalid = rv; imem_bus.imem_rdata = rd;
    imem_bus.imem_pc = pc; load_use_hazard = haz; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load_use_hazard = 1'b0; flush = 1'b0;
    imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0; imem_bus.imem_pc = '0;

    //            rst rv  rdata          pc     haz fl   ev  instr          pc     rdy cnt
    tbl[0]  = '{1'b0,1'b0,32'h0,        32'h00,1'b0,1'b0,1'b0,NOP,          32'h00,1'b1,0};
    tbl[1]  = '{1'b0,1'b0,32'h0,        32'h00,1'b0,1'b0,1'b0,NOP,          32'h00,1'b1,0};
    tbl[2]  = '{1'b1,1'b1,32'h00500093, 32'h00,1'b0,1'b0,1'b1,32'h00500093, 32'h00,1'b1,0};
    tbl[3]  = '{1'b1,1'b1,32'h00108133, 32'h04,1'b0,1'b0,1'b1,32'h00108133, 32'h04,1'b1,0};
    tbl[4]  = '{1'b1,1'b1,32'h0000A103, 32'h08,1'b0,1'b0,1'b1,32'h0000A103, 32'h08,1'b1,0};
    tbl[5]  = '{1'b1,1'b1,32'h00210233, 32'h0C,1'b1,1'b0,1'b1,32'h0000A103, 32'h08,1'b0,1};
    tbl[6]  = '{1'b1,1'b1,32'h11111111, 32'h10,1'b0,1'b0,1'b1,32'h00210233, 32'h0C,1'b1,1};
    tbl[7]  = '{1'b1,1'b1,32'h00310293, 32'h10,1'b1,1'b0,1'b1,32'h00210233, 32'h0C,1'b0,2};
    tbl[8]  = '{1'b1,1'b1,32'h22222222, 32'h14,1'b1,1'b0,1'b1,32'h00210233, 32'h0C,1'b0,3};
    tbl[9]  = '{1'b1,1'b1,32'h22222222, 32'h14,1'b1,1'b0,1'b1,32'h00210233, 32'h0C,1'b0,4};
    tbl[10] = '{1'b1,1'b1,32'h33333333, 32'h18,1'b1,1'b1,1'b0,NOP,          32'h00,1'b1,4};
    tbl[11] = '{1'b1,1'b1,32'h00000063, 32'h20,1'b0,1'b1,1'b0,NOP,          32'h00,1'b1,4};
    tbl[12] = '{1'b1,1'b0,32'h0,        32'h00,1'b0,1'b0,1'b0,NOP,          32'h00,1'b1,4};
    tbl[13] = '{1'b1,1'b1,32'h00400313, 32'h24,1'b1,1'b0,1'b0,NOP,          32'h00,1'b0,4};
    tbl[14] = '{1'b1,1'b0,32'h0,        32'h00,1'b0,1'b0,1'b1,32'h00400313, 32'h24,1'b1,4};
    tbl[15] = '{1'b1,1'b1,32'h00500393, 32'h28,1'b0,1'b0,1'b1,32'h00500393, 32'h28,1'b1,4};

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].rst_n, tbl[i].rv, tbl[i].rd, tbl[i].pc, tbl[i].haz, tbl[i].fl);
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].erdy, tbl[i].ecnt);
    end

    // Long stall on a valid stage with the skid filled on the first cycle:
    // counter climbs from 4 and must pin at all-ones.
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, (i == 0), 32'h00600413, 32'h2C, 1'b1, 1'b0);
      check($sformatf("sat%0d", i), 1'b1, 32'h00500393, 32'h28, 1'b0,
            (4 + i + 1 > CMAX) ? CMAX : 4 + i + 1);
    end

    // One reset edge mid-stall with the skid full clears everything.
    apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("rst_mid_stall", 1'b0, NOP, 32'h0, 1'b1, 0);
    // Skid contents are gone: releasing the stall yields a bubble.
    apply(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("skid_lost", 1'b0, NOP, 32'h0, 1'b1, 0);

    // Random traffic against the reference model.
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      logic        r, rv, haz, fl;
      logic [31:0] rd, pc;
      r   = ($urandom % 64) != 0;
      rv  = ($urandom % 4) != 0;
      rd  = $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      haz = ($urandom % 3) == 0;
      fl  = ($urandom % 10) == 0;
      model_step(r, rv, rd, pc, haz, fl);
      apply(r, rv, rd, pc, haz, fl);
      check($sformatf("rnd%0d", i), m_v, m_i, m_pc, (m_skid.size() == 0), m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
